// File: rtl/alu_issue.sv
// alu_issue: RV64I decode/issue stage feeding the integer ALU through a 2-entry skid buffer.
// Define ALU_ISSUE_WORD_OPS_EN to also decode OP-32 / OP-IMM-32 word operations.
module alu_issue #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid_i,
    output logic            instr_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [4:0]      rs1_addr_o,
    output logic [4:0]      rs2_addr_o,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            flush_i,
    output logic            ex_valid_o,
    input  logic            ex_ready_i,
    output logic [XLEN-1:0] opr_a_o,
    output logic [XLEN-1:0] opr_b_o,
    output logic [3:0]      op_sel_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_wen_o,
    output logic            illegal_o,
    output logic            word_op_o
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SRL  = 4'd3;
    localparam logic [3:0] OP_SRA  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
`ifdef ALU_ISSUE_WORD_OPS_EN
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
`endif

    typedef struct packed {
        logic [XLEN-1:0] opr_a;
        logic [XLEN-1:0] opr_b;
        logic [3:0]      op_sel;
        logic [4:0]      rd_addr;
        logic            rd_wen;
        logic            illegal;
        logic            word_op;
    } payload_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [5:0]      funct6;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt6;
    logic            legal;
    payload_t        dec;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign funct6 = instr_i[31:26];
    assign rd     = instr_i[11:7];
    assign imm_i  = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
    assign imm_u  = {{(XLEN-32){instr_i[31]}}, instr_i[31:12], 12'h000};
    assign shamt6 = {{(XLEN-6){1'b0}}, instr_i[25:20]};

    assign rs1_addr_o = instr_i[19:15];
    assign rs2_addr_o = instr_i[24:20];

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        dec   = '0;
        legal = 1'b1;
        case (opcode)
            OPC_OP: begin
                dec.opr_a = rs1_data_i;
                dec.opr_b = rs2_data_i;
                case ({funct7, funct3})
                    10'b0000000_000: dec.op_sel = OP_ADD;
                    10'b0000000_001: dec.op_sel = OP_SLL;
                    10'b0000000_010: dec.op_sel = OP_SLT;
                    10'b0000000_011: dec.op_sel = OP_SLTU;
                    10'b0000000_100: dec.op_sel = OP_XOR;
                    10'b0000000_101: dec.op_sel = OP_SRL;
                    10'b0000000_110: dec.op_sel = OP_OR;
                    10'b0000000_111: dec.op_sel = OP_AND;
                    10'b0100000_000: dec.op_sel = OP_SUB;
                    10'b0100000_101: dec.op_sel = OP_SRA;
                    default:         legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                dec.opr_a = rs1_data_i;
                dec.opr_b = imm_i;
                case (funct3)
                    3'b000: dec.op_sel = OP_ADD;
                    3'b010: dec.op_sel = OP_SLT;
                    3'b011: dec.op_sel = OP_SLTU;
                    3'b100: dec.op_sel = OP_XOR;
                    3'b110: dec.op_sel = OP_OR;
                    3'b111: dec.op_sel = OP_AND;
                    3'b001: begin
                        dec.opr_b  = shamt6;
                        dec.op_sel = OP_SLL;
                        legal      = (funct6 == 6'b000000);
                    end
                    default: begin
                        dec.opr_b = shamt6;
                        if (funct6 == 6'b000000)      dec.op_sel = OP_SRL;
                        else if (funct6 == 6'b010000) dec.op_sel = OP_SRA;
                        else                          legal = 1'b0;
                    end
                endcase
            end
            OPC_LUI: begin
                dec.opr_b = imm_u;
            end
            OPC_AUIPC: begin
                dec.opr_a = pc_i;
                dec.opr_b = imm_u;
            end
`ifdef ALU_ISSUE_WORD_OPS_EN
            OPC_OP_32: begin
                dec.opr_a   = rs1_data_i;
                dec.opr_b   = rs2_data_i;
                dec.word_op = 1'b1;
                case ({funct7, funct3})
                    10'b0000000_000: dec.op_sel = OP_ADD;
                    10'b0000000_001: dec.op_sel = OP_SLL;
                    10'b0000000_101: dec.op_sel = OP_SRL;
                    10'b0100000_000: dec.op_sel = OP_SUB;
                    10'b0100000_101: dec.op_sel = OP_SRA;
                    default:         legal = 1'b0;
                endcase
            end
            OPC_OP_IMM_32: begin
                dec.opr_a   = rs1_data_i;
                dec.word_op = 1'b1;
                // Word shifts take a 5-bit shamt; instr[25] set falls out as a bad funct7.
                dec.opr_b   = {{(XLEN-5){1'b0}}, instr_i[24:20]};
                case ({funct7, funct3})
                    10'b0000000_001: dec.op_sel = OP_SLL;
                    10'b0000000_101: dec.op_sel = OP_SRL;
                    10'b0100000_101: dec.op_sel = OP_SRA;
                    default: begin
                        if (funct3 == 3'b000) dec.opr_b = imm_i;
                        else                  legal = 1'b0;
                    end
                endcase
            end
`endif
            default: legal = 1'b0;
        endcase

        dec.rd_addr = rd;
        dec.rd_wen  = legal && (rd != 5'd0);
        dec.illegal = !legal;
        if (!legal) begin
            dec.opr_a   = '0;
            dec.opr_b   = '0;
            dec.op_sel  = OP_ADD;
            dec.word_op = 1'b0;
        end
    end

    payload_t main_q, skid_q, main_n, skid_n;
    logic     main_v, skid_v, main_v_n, skid_v_n;
    logic     ready_q;
    logic     accept;

    assign accept = instr_valid_i && ready_q && !flush_i;

    // Skid only fills while main is stalled, so main is never empty while skid holds data.
    always_comb begin
        main_n   = main_q;
        skid_n   = skid_q;
        main_v_n = main_v;
        skid_v_n = skid_v;
        if (flush_i) begin
            main_v_n = 1'b0;
            skid_v_n = 1'b0;
        end else if (!main_v || ex_ready_i) begin
            if (skid_v) begin
                main_n   = skid_q;
                main_v_n = 1'b1;
                skid_v_n = 1'b0;
            end else if (accept) begin
                main_n   = dec;
                main_v_n = 1'b1;
            end else begin
                main_v_n = 1'b0;
            end
        end else if (accept) begin
            skid_n   = dec;
            skid_v_n = 1'b1;
        end
    end

    // NOTE: payload registers are reset too, so every ex output reads 0 straight out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q  <= '0;
            skid_q  <= '0;
            main_v  <= 1'b0;
            skid_v  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            main_q  <= main_n;
            skid_q  <= skid_n;
            main_v  <= main_v_n;
            skid_v  <= skid_v_n;
            ready_q <= !skid_v_n;
        end
    end

    assign instr_ready_o = ready_q;
    assign ex_valid_o    = main_v;
    assign opr_a_o       = main_q.opr_a;
    assign opr_b_o       = main_q.opr_b;
    assign op_sel_o      = main_q.op_sel;
    assign rd_addr_o     = main_q.rd_addr;
    assign rd_wen_o      = main_q.rd_wen;
    assign illegal_o     = main_q.illegal;
    assign word_op_o     = main_q.word_op;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed vector table, hand-written skid/flush/reset sequences, and a
// randomized run checked against a mask/match instruction-table model with an in-order queue.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] pc;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [63:0] rs1_data, rs2_data;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [63:0] opr_a, opr_b;
    logic [3:0]  op_sel;
    logic [4:0]  rd_addr;
    logic        rd_wen, illegal, word_op;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk(clk), .reset(reset),
        .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
        .instr_i(instr), .pc_i(pc),
        .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr),
        .rs1_data_i(rs1_data), .rs2_data_i(rs2_data),
        .flush_i(flush),
        .ex_valid_o(ex_valid), .ex_ready_i(ex_ready),
        .opr_a_o(opr_a), .opr_b_o(opr_b), .op_sel_o(op_sel),
        .rd_addr_o(rd_addr), .rd_wen_o(rd_wen),
        .illegal_o(illegal), .word_op_o(word_op)
    );

    int nvec  = 0;
    int nfail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
        logic        word;
    } res_t;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] pc;
        logic [63:0] r1;
        logic [63:0] r2;
        res_t        exp;
    } vec_t;

    typedef enum {F_R, F_I, F_SH6, F_SH5, F_LUI, F_AUIPC} fmt_e;
    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        logic [3:0]  op;
        fmt_e        fmt;
        logic        word;
    } rule_t;

    rule_t rules[$];
    vec_t  tbl[$];
    res_t  q[$];

    function automatic rule_t rl(logic [31:0] m, logic [31:0] mt, logic [3:0] op, fmt_e f, logic w);
        rule_t r;
        r.mask = m; r.match = mt; r.op = op; r.fmt = f; r.word = w;
        return r;
    endfunction

    function automatic vec_t mkv(logic [31:0] ins, logic [63:0] vpc, logic [63:0] r1, logic [63:0] r2,
                                 logic [63:0] a, logic [63:0] b, logic [3:0] op, logic [4:0] rd,
                                 logic wen, logic ill, logic word);
        vec_t v;
        v.ins = ins; v.pc = vpc; v.r1 = r1; v.r2 = r2;
        v.exp.a = a; v.exp.b = b; v.exp.op = op; v.exp.rd = rd;
        v.exp.wen = wen; v.exp.ill = ill; v.exp.word = word;
        return v;
    endfunction

    // Reference decode: first matching entry of the legal-instruction table wins.
    function automatic res_t model(logic [31:0] ins, logic [63:0] vpc, logic [63:0] r1, logic [63:0] r2);
        res_t r;
        r.a = 0; r.b = 0; r.op = 0; r.wen = 0; r.ill = 1; r.word = 0;
        r.rd = ins[11:7];
        foreach (rules[i]) begin
            if (r.ill && ((ins & rules[i].mask) == rules[i].match)) begin
                r.ill  = 0;
                r.op   = rules[i].op;
                r.word = rules[i].word;
                r.wen  = (ins[11:7] != 0);
                case (rules[i].fmt)
                    F_R:     begin r.a = r1;  r.b = r2; end
                    F_I:     begin r.a = r1;  r.b = {{52{ins[31]}}, ins[31:20]}; end
                    F_SH6:   begin r.a = r1;  r.b = 64'(ins[25:20]); end
                    F_SH5:   begin r.a = r1;  r.b = 64'(ins[24:20]); end
                    F_LUI:   begin r.a = 0;   r.b = {{32{ins[31]}}, ins[31:12], 12'h000}; end
                    default: begin r.a = vpc; r.b = {{32{ins[31]}}, ins[31:12], 12'h000}; end
                endcase
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] mk_addi(logic [4:0] rd, logic [11:0] imm);
        return {imm, 5'd1, 3'b000, rd, 7'h13};
    endfunction

    function automatic logic [31:0] gen_instr();
        int k;
        rule_t r;
        logic [31:0] opcs [4];
        opcs[0] = 32'h33; opcs[1] = 32'h13; opcs[2] = 32'h3B; opcs[3] = 32'h1B;
        k = $urandom_range(0, 9);
        if (k < 7) begin
            r = rules[$urandom_range(0, rules.size() - 1)];
            return ($urandom & ~r.mask) | r.match;
        end else if (k < 9) begin
            return $urandom;
        end
        return ($urandom & ~32'h7F) | opcs[$urandom_range(0, 3)];
    endfunction

    task automatic check_out(input string tag, input res_t e);
        check({tag, "_ex_valid"}, ex_valid, 1);
        check({tag, "_opr_a"},    opr_a,    e.a);
        check({tag, "_opr_b"},    opr_b,    e.b);
        check({tag, "_op_sel"},   op_sel,   e.op);
        check({tag, "_rd_addr"},  rd_addr,  e.rd);
        check({tag, "_rd_wen"},   rd_wen,   e.wen);
        check({tag, "_illegal"},  illegal,  e.ill);
        check({tag, "_word_op"},  word_op,  e.word);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; instr_valid = 0; flush = 0; ex_ready = 0;
        instr = 0; pc = 0; rs1_data = 0; rs2_data = 0;
        next_cycle();
        next_cycle();
        reset = 0;
    endtask

    localparam logic [63:0] R1 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] R2 = 64'hFEDC_BA98_7654_3210;

    initial begin
        rules.push_back(rl(32'hFE00707F, 32'h00000033, 4'd0, F_R, 0));
        rules.push_back(rl(32'hFE00707F, 32'h40000033, 4'd1, F_R, 0));
        rules.push_back(rl(32'hFE00707F, 32'h00001033, 4'd2, F_R, 0));
        rules.push_back(rl(32'hFE00707F, 32'h00002033, 4'd9, F_R, 0));
        rules.push_back(rl(32'hFE00707F, 32'h00003033, 4'd8, F_R, 0));
        rules.push_back(rl(32'hFE00707F, 32'h00004033, 4'd7, F_R, 0));
        rules.push_back(rl(32'hFE00707F, 32'h00005033, 4'd3, F_R, 0));
        rules.push_back(rl(32'hFE00707F, 32'h40005033, 4'd4, F_R, 0));
        rules.push_back(rl(32'hFE00707F, 32'h00006033, 4'd5, F_R, 0));
        rules.push_back(rl(32'hFE00707F, 32'h00007033, 4'd6, F_R, 0));
        rules.push_back(rl(32'h0000707F, 32'h00000013, 4'd0, F_I, 0));
        rules.push_back(rl(32'h0000707F, 32'h00002013, 4'd9, F_I, 0));
        rules.push_back(rl(32'h0000707F, 32'h00003013, 4'd8, F_I, 0));
        rules.push_back(rl(32'h0000707F, 32'h00004013, 4'd7, F_I, 0));
        rules.push_back(rl(32'h0000707F, 32'h00006013, 4'd5, F_I, 0));
        rules.push_back(rl(32'h0000707F, 32'h00007013, 4'd6, F_I, 0));
        rules.push_back(rl(32'hFC00707F, 32'h00001013, 4'd2, F_SH6, 0));
        rules.push_back(rl(32'hFC00707F, 32'h00005013, 4'd3, F_SH6, 0));
        rules.push_back(rl(32'hFC00707F, 32'h40005013, 4'd4, F_SH6, 0));
        rules.push_back(rl(32'h0000007F, 32'h00000037, 4'd0, F_LUI, 0));
        rules.push_back(rl(32'h0000007F, 32'h00000017, 4'd0, F_AUIPC, 0));
`ifdef ALU_ISSUE_WORD_OPS_EN
        rules.push_back(rl(32'hFE00707F, 32'h0000003B, 4'd0, F_R, 1));
        rules.push_back(rl(32'hFE00707F, 32'h4000003B, 4'd1, F_R, 1));
        rules.push_back(rl(32'hFE00707F, 32'h0000103B, 4'd2, F_R, 1));
        rules.push_back(rl(32'hFE00707F, 32'h0000503B, 4'd3, F_R, 1));
        rules.push_back(rl(32'hFE00707F, 32'h4000503B, 4'd4, F_R, 1));
        rules.push_back(rl(32'h0000707F, 32'h0000001B, 4'd0, F_I, 1));
        rules.push_back(rl(32'hFE00707F, 32'h0000101B, 4'd2, F_SH5, 1));
        rules.push_back(rl(32'hFE00707F, 32'h0000501B, 4'd3, F_SH5, 1));
        rules.push_back(rl(32'hFE00707F, 32'h4000501B, 4'd4, F_SH5, 1));
`endif

        // Directed vectors with hand-derived expectations.
        tbl.push_back(mkv(32'hFFF08293, 0, 64'h10, 0, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 0, 5, 1, 0, 0));
        tbl.push_back(mkv(32'h402081B3, 0, R1, R2, R1, R2, 1, 3, 1, 0, 0));
        tbl.push_back(mkv(32'h43F3D393, 0, 64'h8000_0000_0000_0000, 0, 64'h8000_0000_0000_0000, 63, 4, 7, 1, 0, 0));
        tbl.push_back(mkv(32'h800000B7, 64'h40, R1, R2, 0, 64'hFFFF_FFFF_8000_0000, 0, 1, 1, 0, 0));
        tbl.push_back(mkv(32'h00001117, 64'h1000, R1, R2, 64'h1000, 64'h1000, 0, 2, 1, 0, 0));
        tbl.push_back(mkv(32'h00000000, 64'h40, R1, R2, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mkv(32'h022081B3, 0, R1, R2, 0, 0, 0, 3, 0, 1, 0));
`ifdef ALU_ISSUE_WORD_OPS_EN
        tbl.push_back(mkv(32'h002081BB, 0, R1, R2, R1, R2, 0, 3, 1, 0, 1));
`else
        tbl.push_back(mkv(32'h002081BB, 0, R1, R2, 0, 0, 0, 3, 0, 1, 0));
`endif
        tbl.push_back(mkv(32'h00208033, 0, R1, R2, R1, R2, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(32'h0050B213, 0, R1, R2, R1, 5, 8, 4, 1, 0, 0));
        tbl.push_back(mkv(32'h04009093, 0, R1, R2, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mkv(32'h0020C333, 0, R1, R2, R1, R2, 7, 6, 1, 0, 0));
        tbl.push_back(mkv(32'h0020A1B3, 0, R1, R2, R1, R2, 9, 3, 1, 0, 0));
        tbl.push_back(mkv(32'h4020D1B3, 0, R1, R2, R1, R2, 4, 3, 1, 0, 0));
        tbl.push_back(mkv(32'h402091B3, 0, R1, R2, 0, 0, 0, 3, 0, 1, 0));
        tbl.push_back(mkv(32'h8000F093, 0, R1, R2, R1, 64'hFFFF_FFFF_FFFF_F800, 6, 1, 1, 0, 0));

        // Reset state.
        do_reset();
        @(negedge clk);
        check("rst_ex_valid", ex_valid, 0);
        check("rst_ready",    instr_ready, 1);
        check("rst_opr_a",    opr_a, 0);
        check("rst_opr_b",    opr_b, 0);
        check("rst_op_sel",   op_sel, 0);
        check("rst_rd",       {rd_wen, rd_addr}, 0);
        check("rst_ill_word", {illegal, word_op}, 0);
        next_cycle();

        // Table: one instruction per slot, result one cycle after accept.
        foreach (tbl[i]) begin
            instr_valid = 1; ex_ready = 1;
            instr = tbl[i].ins; pc = tbl[i].pc; rs1_data = tbl[i].r1; rs2_data = tbl[i].r2;
            #1;
            check($sformatf("v%0d_rs1_addr", i), rs1_addr, tbl[i].ins[19:15]);
            check($sformatf("v%0d_rs2_addr", i), rs2_addr, tbl[i].ins[24:20]);
            next_cycle();
            instr_valid = 0;
            @(negedge clk);
            check_out($sformatf("v%0d", i), tbl[i].exp);
            next_cycle();
        end
        @(negedge clk);
        check("tbl_drained", ex_valid, 0);
        next_cycle();

        // Skid: three back-to-back with ALU stalled, then release.
        rs1_data = 0; ex_ready = 0; instr_valid = 1; instr = mk_addi(5'd1, 12'd1);
        @(negedge clk); check("skid_rdy_a", instr_ready, 1);
        next_cycle(); instr = mk_addi(5'd2, 12'd2);
        @(negedge clk); check("skid_v1", ex_valid, 1); check("skid_rdy_b", instr_ready, 1);
        check("skid_b1", opr_b, 1);
        next_cycle(); instr = mk_addi(5'd3, 12'd3);
        @(negedge clk); check("skid_full_rdy", instr_ready, 0); check("skid_hold_b", opr_b, 1);
        next_cycle(); ex_ready = 1;
        @(negedge clk); check("skid_still_full", instr_ready, 0); check("skid_hold_b2", opr_b, 1);
        next_cycle();
        @(negedge clk); check("skid_2nd_b", opr_b, 2); check("skid_2nd_rd", rd_addr, 2);
        check("skid_rdy_back", instr_ready, 1); check("skid_2nd_v", ex_valid, 1);
        next_cycle(); instr_valid = 0;
        @(negedge clk); check("skid_3rd_b", opr_b, 3); check("skid_3rd_v", ex_valid, 1);
        next_cycle();
        @(negedge clk); check("skid_empty", ex_valid, 0);
        next_cycle();

        // Flush with both entries full and an instruction offered.
        ex_ready = 0; instr_valid = 1; instr = mk_addi(5'd1, 12'd1);
        next_cycle(); instr = mk_addi(5'd2, 12'd2);
        next_cycle(); instr = mk_addi(5'd3, 12'd3); flush = 1;
        @(negedge clk); check("fl_full_rdy", instr_ready, 0);
        next_cycle(); flush = 0; instr_valid = 0;
        @(negedge clk); check("fl_full_v", ex_valid, 0); check("fl_full_rdy1", instr_ready, 1);
        next_cycle();
        @(negedge clk); check("fl_full_drop", ex_valid, 0);
        next_cycle();

        // Flush while ready: the offered instruction must be dropped.
        instr_valid = 1; instr = mk_addi(5'd4, 12'd4);
        next_cycle(); flush = 1; instr = mk_addi(5'd5, 12'd5);
        @(negedge clk); check("fl_one_rdy", instr_ready, 1);
        next_cycle(); flush = 0; instr_valid = 0;
        @(negedge clk); check("fl_one_v", ex_valid, 0); check("fl_one_rdy1", instr_ready, 1);
        next_cycle();

        // Reset mid-operation with the buffer full.
        instr_valid = 1; instr = mk_addi(5'd6, 12'd6);
        next_cycle(); instr = mk_addi(5'd7, 12'd7);
        next_cycle(); instr_valid = 0;
        #2 reset = 1;
        #1;
        check("mrst_v", ex_valid, 0); check("mrst_rdy", instr_ready, 1);
        check("mrst_b", opr_b, 0); check("mrst_rd", {rd_wen, rd_addr}, 0);
        next_cycle(); reset = 0;
        @(negedge clk); check("mrst_v2", ex_valid, 0); check("mrst_rdy2", instr_ready, 1);
        next_cycle();

        // Randomized run against the queue model.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic acc, xfer;
            instr_valid = ($urandom_range(0, 9) < 7);
            instr       = gen_instr();
            pc          = {$urandom, $urandom};
            rs1_data    = {$urandom, $urandom};
            rs2_data    = {$urandom, $urandom};
            ex_ready    = ($urandom_range(0, 9) < 6);
            flush       = ($urandom_range(0, 24) == 0);
            @(negedge clk);
            check("rnd_ex_valid", ex_valid, q.size() > 0);
            check("rnd_ready", instr_ready, q.size() < 2);
            check("rnd_rs1_addr", rs1_addr, instr[19:15]);
            if (q.size() > 0) check_out("rnd", q[0]);
            acc  = instr_valid && (q.size() < 2) && !flush;
            xfer = (q.size() > 0) && ex_ready;
            if (xfer) void'(q.pop_front());
            if (flush) q.delete();
            else if (acc) q.push_back(model(instr, pc, rs1_data, rs2_data));
            next_cycle();
        end

        instr_valid = 0; flush = 0; ex_ready = 0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
